// File: rtl/rs_ooo_pkg.sv
// Shared constants for the out-of-order reservation station: default widths,
// the empty-tag value and boolean helpers.
package rs_ooo_pkg;
   localparam int   DEF_DEPTH     = 16;
   localparam int   DEF_CDB_PORTS = 2;
   localparam int   DEF_TAG_W     = 5;
   localparam int   DEF_DATA_W    = 32;
   localparam int   DEF_INFO_W    = 75;
   localparam int   TAG_EMPTY     = 0;
   localparam logic TRUE          = 1'b1;
   localparam logic FALSE         = 1'b0;
endpackage

// File: rtl/rs_age_sel.sv
// Oldest-first selector: an age matrix updated on allocation picks the
// requesting entry that no other requesting entry predates.
module rs_age_sel
   import rs_ooo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] alloc,
   input  logic [DEPTH-1:0] req,
   output logic [DEPTH-1:0] grant,
   output logic             grant_valid
);

   // older[i][j] is set when entry i was dispatched before entry j.
   logic [DEPTH-1:0][DEPTH-1:0] older;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         older <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (alloc[i]) begin
                  older[i][j] <= FALSE;
               end else if (alloc[j]) begin
                  older[i][j] <= TRUE;
               end
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = req[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && req[j] && older[j][i]) begin
               grant[i] = FALSE;
            end
         end
      end
      grant_valid = |req;
   end

endmodule

// File: rtl/rs_ooo.sv
// Reservation station: holds dispatched ops until both operands arrive over
// the CDB, then issues the oldest ready op through a one-deep output register.
module rs_ooo
   import rs_ooo_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int CDB_PORTS = DEF_CDB_PORTS,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int INFO_W    = DEF_INFO_W
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic                        clear,
   input  logic                        disp_valid,
   output logic                        disp_ready,
   input  logic [INFO_W-1:0]           disp_info,
   input  logic [TAG_W-1:0]            disp_q1,
   input  logic [TAG_W-1:0]            disp_q2,
   input  logic [DATA_W-1:0]           disp_v1,
   input  logic [DATA_W-1:0]           disp_v2,
   input  logic [CDB_PORTS-1:0]        cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
   input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
   output logic                        iss_valid,
   input  logic                        iss_ready,
   output logic [INFO_W-1:0]           iss_info,
   output logic [DATA_W-1:0]           iss_v1,
   output logic [DATA_W-1:0]           iss_v2,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OPR_W = TAG_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   // Handshakes: a dispatch transfers on an edge with rdy && disp_valid &&
   // disp_ready; an issue transfers on an edge with rdy && iss_valid &&
   // iss_ready, and iss_* stay frozen while iss_valid && !iss_ready.

   logic [DEPTH-1:0]  busy;
   logic [TAG_W-1:0]  q1_r   [DEPTH];
   logic [TAG_W-1:0]  q2_r   [DEPTH];
   logic [DATA_W-1:0] v1_r   [DEPTH];
   logic [DATA_W-1:0] v2_r   [DEPTH];
   logic [INFO_W-1:0] info_r [DEPTH];

   logic [OPR_W-1:0]  w1 [DEPTH];
   logic [OPR_W-1:0]  w2 [DEPTH];
   logic [OPR_W-1:0]  d1, d2;
   logic [DEPTH-1:0]  req, gnt, alloc_vec;
   logic              gnt_valid, disp_fire, ld, iss_fire;
   logic [IDX_W-1:0]  free_idx;
   logic [INFO_W-1:0] sel_info;
   logic [DATA_W-1:0] sel_v1, sel_v2;

   // Returns {tag, value} after snooping the CDB; the loop runs high to low so
   // the lowest matching port is the one that sticks.
   function automatic logic [OPR_W-1:0] wake(input logic [TAG_W-1:0] q,
                                             input logic [DATA_W-1:0] v);
      logic [TAG_W-1:0]  nq;
      logic [DATA_W-1:0] nv;
      nq = q;
      nv = v;
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
         if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] != TAG_W'(TAG_EMPTY)
             && cdb_tag[p*TAG_W +: TAG_W] == q) begin
            nq = TAG_W'(TAG_EMPTY);
            nv = cdb_data[p*DATA_W +: DATA_W];
         end
      end
      return {nq, nv};
   endfunction

   assign disp_ready = (count != FULL);
   assign disp_fire  = rdy && disp_valid && disp_ready && !clear;
   assign ld         = (!iss_valid || iss_ready) && rdy;
   assign iss_fire   = ld && gnt_valid && !clear;
   assign d1         = wake(disp_q1, disp_v1);
   assign d2         = wake(disp_q2, disp_v2);

   always_comb begin
      free_idx  = '0;
      alloc_vec = '0;
      req       = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx = IDX_W'(i);
         end
      end
      if (disp_fire) begin
         alloc_vec[free_idx] = TRUE;
      end
      for (int i = 0; i < DEPTH; i++) begin
         w1[i]  = wake(q1_r[i], v1_r[i]);
         w2[i]  = wake(q2_r[i], v2_r[i]);
         req[i] = busy[i] && q1_r[i] == TAG_W'(TAG_EMPTY)
                  && q2_r[i] == TAG_W'(TAG_EMPTY);
      end
   end

   rs_age_sel #(.DEPTH(DEPTH)) u_age_sel (
      .clk         (clk),
      .rst         (rst),
      .alloc       (alloc_vec),
      .req         (req),
      .grant       (gnt),
      .grant_valid (gnt_valid)
   );

   always_comb begin
      sel_info = '0;
      sel_v1   = '0;
      sel_v2   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt[i]) begin
            sel_info = info_r[i];
            sel_v1   = v1_r[i];
            sel_v2   = v2_r[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= '0;
         count     <= '0;
         iss_valid <= FALSE;
         iss_info  <= '0;
         iss_v1    <= '0;
         iss_v2    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q1_r[i]   <= '0;
            q2_r[i]   <= '0;
            v1_r[i]   <= '0;
            v2_r[i]   <= '0;
            info_r[i] <= '0;
         end
      end else if (rdy) begin
         if (clear) begin
            busy      <= '0;
            count     <= '0;
            iss_valid <= FALSE;
            for (int i = 0; i < DEPTH; i++) begin
               q1_r[i] <= '0;
               q2_r[i] <= '0;
            end
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (alloc_vec[i]) begin
                  busy[i]              <= TRUE;
                  {q1_r[i], v1_r[i]}   <= d1;
                  {q2_r[i], v2_r[i]}   <= d2;
                  info_r[i]            <= disp_info;
               end else if (busy[i]) begin
                  {q1_r[i], v1_r[i]}   <= w1[i];
                  {q2_r[i], v2_r[i]}   <= w2[i];
                  if (iss_fire && gnt[i]) begin
                     busy[i] <= FALSE;
                  end
               end
            end
            if (ld) begin
               iss_valid <= gnt_valid;
               if (gnt_valid) begin
                  iss_info <= sel_info;
                  iss_v1   <= sel_v1;
                  iss_v2   <= sel_v2;
               end
            end
            count <= count + CNT_W'(disp_fire) - CNT_W'(iss_fire);
         end
      end
   end

endmodule

// File: doc/rs_ooo.md
RS_OOO -- requirements
Module: rs_ooo

Interface
REQ-001 SHALL have parameters:
- DEPTH, 16: number of entries, power of 2, >=2; all entries usable.
- CDB_PORTS, 2: number of broadcast ports.
- TAG_W, 5: ROB tag width; tag 0 means "no dependency".
- DATA_W, 32: operand width.
- INFO_W, 75: opaque payload (op, imm, pc, dest) carried unmodified.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- rdy, in, 1: global enable; low freezes all state.
- clear, in, 1: synchronous mispredict flush.
- disp_valid, in, 1: dispatch request.
- disp_ready, out, 1: a free entry exists.
- disp_info, in, INFO_W: payload.
- disp_q1 / disp_q2, in, TAG_W each: source tags.
- disp_v1 / disp_v2, in, DATA_W each: source values, valid when the tag is 0.
- cdb_valid, in, CDB_PORTS: broadcast valid per port.
- cdb_tag, in, CDB_PORTS*TAG_W: broadcast tags, port 0 in the LSBs.
- cdb_data, in, CDB_PORTS*DATA_W: broadcast data.
- iss_valid, out, 1: registered issue valid.
- iss_ready, in, 1: execute unit accepts.
- iss_info, out, INFO_W: issued payload.
- iss_v1 / iss_v2, out, DATA_W each: issued operands.
- count, out, $clog2(DEPTH+1): occupied entries, registered.

Function
REQ-003 SHALL accept a dispatch on an edge where rdy && disp_valid && disp_ready && !clear, writing the lowest-index free entry.
REQ-004 SHALL drive disp_ready = (count != DEPTH), from registered state only; an entry freed on an edge is reusable from the next cycle.
REQ-005 SHALL capture cdb_data into any stored operand whose tag equals a valid, nonzero cdb_tag, and clear that tag to 0, on the same edge.
REQ-006 SHALL apply the REQ-005 match to the dispatching operands in the same cycle (bypass), so no broadcast is lost.
REQ-007 SHALL, when two CDB ports carry an equal tag, take data from the lower port index.
REQ-008 SHALL ignore a CDB port whose tag is 0, even when it is valid.
REQ-009 SHALL treat an entry as ready when it is occupied and both tags are 0.
REQ-010 SHALL select the oldest ready entry by dispatch order (age matrix or per-entry sequence), not by index.
REQ-011 SHALL treat the output stage as a one-deep register with load condition (!iss_valid || iss_ready) && rdy. On a load it takes the selected entry, frees it, and sets iss_valid; it clears iss_valid when nothing is ready.
REQ-012 SHALL hold iss_valid/iss_info/iss_v1/iss_v2 stable while iss_valid && !iss_ready.
REQ-013 SHALL give a minimum latency of one edge from a dispatch with both tags 0 to iss_valid high, and one edge from the CDB wakeup edge to selection eligibility.
REQ-014 SHALL, in a cycle with dispatch, issue and CDB together, update count by +1, -1 or 0 accordingly.
REQ-015 SHALL, when clear is high on an edge (and rdy is high), empty all entries, zero count and drop iss_valid; a dispatch or CDB in that same cycle is discarded.
REQ-016 SHALL, while rdy is low, change no state and transfer nothing.

Reset
REQ-017 SHALL, while rst is high, asynchronously set all entries free, all tags to 0, age state cleared, iss_valid=0, iss_info/iss_v1/iss_v2=0 and count=0.
REQ-018 SHALL, when rst is deasserted, have disp_ready=1 from the first edge.

Structure
REQ-019 SHALL take the empty-tag constant, the default widths and the TRUE/FALSE constants from the shared defines package.
REQ-020 SHALL implement oldest-ready selection as one sub-module, rs_age_sel (DEPTH-wide request vector in, one-hot grant plus valid out).

Verification
REQ-021 Reset mid-operation: fill 5 entries, assert rst asynchronously between edges -> count=0, iss_valid=0 immediately, disp_ready=1.
REQ-022 Full: dispatch 16 entries all with q1=3 -> count=16, disp_ready=0; CDB tag 3 data 0xAA -> all issue oldest-first, one per cycle, each with iss_v1=0xAA.
REQ-023 Bypass: dispatch q1=7 while cdb_tag[0]=7, data 0x1234, in the same cycle -> iss_valid next cycle with iss_v1=0x1234.
REQ-024 Age order: dispatch A (q1=4) into entry 0, then B (ready) into entry 1, then broadcast tag 4 -> B issues first, then A, regardless of index.
REQ-025 Backpressure: hold iss_ready=0 for 3 cycles with 2 ready entries -> outputs stable, count stays 1; release -> the second issues the next cycle.
REQ-026 Clear: assert clear with dispatch and CDB active, 6 entries held -> next cycle count=0 and iss_valid=0; a later broadcast of the old tag has no effect.
